// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD controller.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int unsigned DIGIT_W = 4;

    function automatic logic [3:0] add3(logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_digit_scan.sv
// Multiplexed 7-seg digit scanner: free-running slot timer, one-cold anode select, digit mux.
// Optional leading-zero blanking when BCD_BLANK_EN is defined.
module bcd_digit_scan
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIGIT_W*DIGITS-1:0]  bcd,
    output logic [DIGITS-1:0]          an,
    output logic [DIGIT_W-1:0]         digit
);

    localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [TICK_W-1:0] tick;
    logic [IDX_W-1:0]  idx;
    logic [DIGITS-1:0] blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick == TICK_W'(SCAN_DIV - 1)) begin
            tick <= '0;
            idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            tick <= tick + TICK_W'(1);
        end
    end

`ifdef BCD_BLANK_EN
    // A digit is blanked when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank      = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (bcd[DIGIT_W*i +: DIGIT_W] == '0);
            blank[i]   = zero_above;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        an    = '1;
        digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                an[i] = blank[i];
                digit = bcd[DIGIT_W*i +: DIGIT_W];
            end
        end
    end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD controller (double dabble, one bit per clock) with display scan.
// Define BCD_BLANK_EN to enable leading-zero blanking on the scanned display.
module bcd_seq_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned IN_W     = 11,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_bin,
    output logic                       out_valid,
    output logic [DIGIT_W*DIGITS-1:0]  bcd,
    output logic                       busy,
    output logic [DIGITS-1:0]          an,
    output logic [DIGIT_W-1:0]         digit
);

    localparam int unsigned ACC_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    state_t            state;
    logic [IN_W-1:0]   shreg;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_adj;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  count;

    // Digits are adjusted independently; the top bit falls off the shift and is always 0 for
    // legal parameter choices.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            acc_adj[DIGIT_W*i +: DIGIT_W] = add3(acc[DIGIT_W*i +: DIGIT_W]);
        end
        acc_next = ACC_W'({acc_adj, shreg[IN_W-1]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            count     <= '0;
            bcd       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_bin;
                        acc      <= '0;
                        count    <= CNT_W'(IN_W);
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc   <= acc_next;
                    shreg <= shreg << 1;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state     <= DONE;
                        bcd       <= acc_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    bcd_digit_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .bcd   (bcd),
        .an    (an),
        .digit (digit)
    );

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed self-checking bench for bcd_seq_ctrl (IN_W=11, DIGITS=4, SCAN_DIV=4).
module tb_bcd_seq_ctrl;

    localparam int unsigned IN_W     = 11;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [IN_W-1:0] in_bin = '0;
    logic            in_ready;
    logic            out_valid;
    logic [15:0]     bcd;
    logic            busy;
    logic [3:0]      an;
    logic [3:0]      digit;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ov_cnt = 0;
    int acc_cyc[$];

    bcd_seq_ctrl #(
        .IN_W     (IN_W),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .bcd       (bcd),
        .busy      (busy),
        .an        (an),
        .digit     (digit)
    );

    always #5 clk = ~clk;

    // Pre-edge view of the handshake: accept cycles and out_valid pulses.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && in_valid && in_ready) acc_cyc.push_back(cyc);
        if (rst_n && out_valid) ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
        check({tag, "_bcd"}, 32'(bcd), 32'(exp));
    endtask

    task automatic convert(input string tag, input logic [IN_W-1:0] val, input logic [15:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = val;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(tag, exp);
    endtask

    task automatic scan_check(input string tag, input logic [15:0] exp_an, input logic [15:0] exp_dig);
        logic [3:0] prev;
        logic       found;
        int         j;
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
            else prev = an;
        end
        check({tag, "_slot0"}, 32'(found), 32'd1);
        if (found) begin
            for (int k = 0; k < 5; k++) begin
                j = k % 4;
                check($sformatf("%s_an%0d", tag, k), 32'(an), 32'(exp_an[4*j +: 4]));
                check($sformatf("%s_dig%0d", tag, k), 32'(digit), 32'(exp_dig[4*j +: 4]));
                repeat (SCAN_DIV) @(negedge clk);
            end
        end
    endtask

    initial begin
        int a0;
        int ov0;
        int n;
        logic [15:0] an_all;
        logic [15:0] an_low;

        an_all = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
`ifdef BCD_BLANK_EN
        an_low = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
`else
        an_low = an_all;
`endif

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_an", 32'(an), 32'hE);
        check("rst_digit", 32'(digit), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 2047, handshake and latency
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = 11'd2047;
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_ready_drop", 32'(in_ready), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t1_latency", 32'(n), 32'd11);
        check("t1_bcd", 32'(bcd), 32'h2047);
        @(negedge clk);
        check("t1_ov_pulse", 32'(out_valid), 32'd0);
        check("t1_ready_back", 32'(in_ready), 32'd1);
        check("t1_busy_back", 32'(busy), 32'd0);

        // 5: scan of 2047
        scan_check("scan2047", an_all, 16'h2047);
        check("t5_bcd_held", 32'(bcd), 32'h2047);

        // 2: 0 then 999 back-to-back
        a0 = acc_cyc.size();
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = 11'd0;
        @(negedge clk);
        in_bin   = 11'd999;
        wait_result("t2_zero", 16'h0000);
        n = 0;
        while (acc_cyc.size() < a0 + 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("t2_two_accepts", 32'(acc_cyc.size() - a0), 32'd2);
        if (acc_cyc.size() >= a0 + 2)
            check("t2_spacing", 32'(acc_cyc[a0+1] - acc_cyc[a0]), 32'd13);
        wait_result("t2_999", 16'h0999);

        // 3: in_valid held during SHIFT is ignored
        a0 = acc_cyc.size();
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = 11'd1234;
        @(negedge clk);
        in_bin   = 11'd55;
        wait_result("t3_1234", 16'h1234);
        check("t3_no_early_accept", 32'(acc_cyc.size() - a0), 32'd1);
        n = 0;
        while (acc_cyc.size() < a0 + 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("t3_second_accept", 32'(acc_cyc.size() - a0), 32'd2);
        if (acc_cyc.size() >= a0 + 2)
            check("t3_spacing", 32'(acc_cyc[a0+1] - acc_cyc[a0]), 32'd13);
        wait_result("t3_55", 16'h0055);

        // 4: reset mid-conversion
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = 11'd2047;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        ov0 = ov_cnt;
        rst_n = 1'b0;
        #1;
        check("t4_bcd", 32'(bcd), 32'h0);
        check("t4_ready", 32'(in_ready), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_ov", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_no_pulse", 32'(ov_cnt - ov0), 32'd0);
        convert("t4_100", 11'd100, 16'h0100);

        // 6: small values on the display
        convert("t6_7", 11'd7, 16'h0007);
        scan_check("scan0007", an_low, 16'h0007);
        convert("t6_0", 11'd0, 16'h0000);
        scan_check("scan0000", an_low, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
